// File: rtl/fmul_pipline3_pkg.sv
// Shared constants and types for the fp32 multiplier final stage and the
// reusable binary32 packer (also used by the adder pipeline's last stage).
package fmul_pipline3_pkg;

  localparam int SIG_W   = 64;       // significand width on x2 (sign excluded)
  localparam int EXP_W   = 9;        // incoming base exponent width
  localparam int MAN_LSB = 24;       // fraction LSB position in the significand
  localparam int NEXP_W  = EXP_W + 1; // widened exponent, holds base 255 + carry

  localparam int FRAC_W   = 23;
  localparam int EXPF_W   = 8;
  localparam int EXP_BIAS = 127;

  localparam logic [EXPF_W-1:0] EXP_INF       = 8'hFF;
  localparam logic [31:0]       FP32_QNAN     = 32'h7FC0_0000;
  localparam logic [31:0]       FP32_POS_INF  = 32'h7F80_0000;
  localparam logic [31:0]       FP32_POS_ZERO = 32'h0000_0000;

  // Normalized operand handed from the normalize stage to the packer
  typedef struct packed {
    logic                     sign;
    logic                     zero;
    logic signed [NEXP_W-1:0] exp;
    logic [FRAC_W-1:0]        frac;
  } norm_t;

  // Packed binary32 plus its classification flags
  typedef struct packed {
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    logic        zero;
  } pack_t;

  // Assemble a binary32 word from its three fields
  function automatic logic [31:0] fp32_make(input logic s,
                                            input logic [EXPF_W-1:0] e,
                                            input logic [FRAC_W-1:0] f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/fmul_pipline3_pack.sv
// fp32_pack: classify a normalized operand (zero / overflow / underflow /
// normal) and pack it as binary32. Purely combinational; the caller registers.
module fp32_pack
  import fmul_pipline3_pkg::*;
(
  input  norm_t norm_i,
  output pack_t pack_o
);

  // Priority classify: zero op, then overflow to inf, then flush, else normal
  always_comb begin
    pack_o.result = FP32_POS_ZERO;
    pack_o.ovf    = 1'b0;
    pack_o.unf    = 1'b0;
    pack_o.zero   = 1'b0;
    if (norm_i.zero) begin
      pack_o.result = fp32_make(norm_i.sign, 8'h00, 23'h0);
      pack_o.zero   = 1'b1;
    end else if (norm_i.exp >= 10'sd255) begin
      pack_o.result = fp32_make(norm_i.sign, EXP_INF, 23'h0);
      pack_o.ovf    = 1'b1;
    end else if (norm_i.exp <= 10'sd0) begin
      pack_o.result = fp32_make(norm_i.sign, 8'h00, 23'h0);
      pack_o.unf    = 1'b1;
    end else begin
      pack_o.result = fp32_make(norm_i.sign, norm_i.exp[EXPF_W-1:0], norm_i.frac);
    end
  end

endmodule

// File: rtl/fmul_pipline3.sv
// fmul_pipline3: last stage of the pipelined fp32 multiplier. Stage A folds the
// rounding carry into the exponent, stage B classifies and packs to binary32.
// Sticky overflow/underflow flags accumulate until cleared.
module fmul_pipline3
  import fmul_pipline3_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [SIG_W:0]     x2,
  input  logic [EXP_W-1:0]   base_ei,
  input  logic               enable,
  input  logic               flag_clr,
  output logic [31:0]        result,
  output logic               ovf,
  output logic               unf,
  output logic               zero,
  output logic               valid,
  output logic               sticky_ovf,
  output logic               sticky_unf
);

  logic [SIG_W-1:0]         sig_s;
  logic signed [NEXP_W-1:0] base_ext_s;
  logic                     sig_unused_s;
  norm_t                    norm_d;
  norm_t                    norm_q;
  logic                     va_q;
  pack_t                    pack_s;
  pack_t                    out_q;
  logic                     valid_q;
  logic                     sticky_ovf_q;
  logic                     sticky_unf_q;

  assign sig_s      = x2[SIG_W-1:0];
  assign base_ext_s = signed'({base_ei[EXP_W-1], base_ei});
  // Guard bits below the fraction and headroom above the carry are don't-care
  assign sig_unused_s = ^{sig_s[SIG_W-1:MAN_LSB+25], sig_s[MAN_LSB-1:0]};

  // Normalize: a rounding carry shifts the fraction right and bumps the exponent
  always_comb begin
    norm_d.sign = x2[SIG_W];
    norm_d.zero = 1'b0;
    norm_d.exp  = base_ext_s;
    norm_d.frac = sig_s[MAN_LSB+22:MAN_LSB];
    if (sig_s[MAN_LSB+24]) begin
      norm_d.frac = sig_s[MAN_LSB+23:MAN_LSB+1];
      norm_d.exp  = base_ext_s + 10'sd1;
    end else if (sig_s[MAN_LSB+23]) begin
      norm_d.frac = sig_s[MAN_LSB+22:MAN_LSB];
      norm_d.exp  = base_ext_s;
    end else begin
      norm_d.zero = 1'b1;
    end
  end

  // Stage A register: capture normalized operand on enable, track its validity
  always_ff @(posedge clk) begin
    if (rst) begin
      norm_q <= '0;
      va_q   <= 1'b0;
    end else begin
      va_q <= enable;
      if (enable) begin
        norm_q <= norm_d;
      end else begin
        norm_q <= norm_q;
      end
    end
  end

  fp32_pack u_pack (
    .norm_i (norm_q),
    .pack_o (pack_s)
  );

  // Stage B register: capture packed result when stage A held a valid op
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= va_q;
      if (va_q) begin
        out_q <= pack_s;
      end else begin
        out_q <= out_q;
      end
    end
  end

  // Sticky flags: a new event wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf_q <= 1'b0;
      sticky_unf_q <= 1'b0;
    end else begin
      sticky_ovf_q <= (sticky_ovf_q & ~flag_clr) | (valid_q & out_q.ovf);
      sticky_unf_q <= (sticky_unf_q & ~flag_clr) | (valid_q & out_q.unf);
    end
  end

  assign result     = out_q.result;
  assign ovf        = out_q.ovf;
  assign unf        = out_q.unf;
  assign zero       = out_q.zero;
  assign valid      = valid_q;
  assign sticky_ovf = sticky_ovf_q;
  assign sticky_unf = sticky_unf_q;

endmodule

// File: tb/tb_fmul_pipline3.sv
// Bench for fmul_pipline3: directed vector table, hand-written pipeline and
// sticky/reset sequences, and randomized traffic against a value-level model.
module tb_fmul_pipline3;

  logic        clk;
  logic        rst;
  logic [64:0] x2;
  logic [8:0]  base_ei;
  logic        enable;
  logic        flag_clr;
  logic [31:0] result;
  logic        ovf, unf, zero, valid, sticky_ovf, sticky_unf;

  int total = 0;
  int bad   = 0;

  fmul_pipline3 dut (
    .clk        (clk),
    .rst        (rst),
    .x2         (x2),
    .base_ei    (base_ei),
    .enable     (enable),
    .flag_clr   (flag_clr),
    .result     (result),
    .ovf        (ovf),
    .unf        (unf),
    .zero       (zero),
    .valid      (valid),
    .sticky_ovf (sticky_ovf),
    .sticky_unf (sticky_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected outputs of one op: {result, ovf, unf, zero}
  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [64:0] x2;
    logic [8:0]  base;
    exp_t        e;
  } vec_t;

  // model state: op in flight after stage A, visible outputs, stickies
  logic ma_v;
  exp_t ma_out;
  logic m_valid;
  exp_t m_out;
  logic m_sovf, m_sunf;

  // Value-level reference: read the 25-bit integer mantissa at the fraction
  // LSB and decide from its magnitude
  function automatic exp_t ref_op(input logic [64:0] xv, input logic [8:0] bv);
    exp_t r;
    int m, b, e, fr;
    logic s;
    s = xv[64];
    m = int'(xv[48:24]);
    b = bv[8] ? int'(bv) - 512 : int'(bv);
    r = '0;
    if (m < (1 << 23)) begin
      r.res = {s, 31'h0};
      r.zero = 1'b1;
      return r;
    end
    if (m >= (1 << 24)) begin
      e = b + 1;
      fr = (m >> 1) & 32'h7F_FFFF;
    end else begin
      e = b;
      fr = m & 32'h7F_FFFF;
    end
    if (e >= 255) begin
      r.res = {s, 8'hFF, 23'h0};
      r.ovf = 1'b1;
    end else if (e <= 0) begin
      r.res = {s, 31'h0};
      r.unf = 1'b1;
    end else begin
      r.res = {s, e[7:0], fr[22:0]};
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // one clock: drive inputs, advance the model, compare every output
  task automatic step(input logic [64:0] xv, input logic [8:0] bv,
                      input logic en, input logic clr, input logic rs);
    x2 = xv; base_ei = bv; enable = en; flag_clr = clr; rst = rs;
    @(posedge clk);
    if (rs) begin
      ma_v = 1'b0; ma_out = '0; m_valid = 1'b0; m_out = '0;
      m_sovf = 1'b0; m_sunf = 1'b0;
    end else begin
      m_sovf = (m_sovf & ~clr) | (m_valid & m_out.ovf);
      m_sunf = (m_sunf & ~clr) | (m_valid & m_out.unf);
      m_valid = ma_v;
      if (ma_v) m_out = ma_out;
      ma_v = en;
      if (en) ma_out = ref_op(xv, bv);
    end
    #1;
    chk("valid",      {31'h0, valid},      {31'h0, m_valid});
    chk("result",     result,              m_out.res);
    chk("ovf",        {31'h0, ovf},        {31'h0, m_out.ovf});
    chk("unf",        {31'h0, unf},        {31'h0, m_out.unf});
    chk("zero",       {31'h0, zero},       {31'h0, m_out.zero});
    chk("sticky_ovf", {31'h0, sticky_ovf}, {31'h0, m_sovf});
    chk("sticky_unf", {31'h0, sticky_unf}, {31'h0, m_sunf});
  endtask

  task automatic idle(input logic clr);
    step(65'h0, 9'h0, 1'b0, clr, 1'b0);
  endtask

  vec_t vecs[15];

  initial begin
    logic [64:0] rx;
    logic [8:0]  rb;
    int          cat;

    vecs[0]  = '{{1'b0, 64'h0000_C000_0000_0000}, 9'd128,  '{32'h4040_0000, 1'b0, 1'b0, 1'b0}};
    vecs[1]  = '{{1'b0, 64'h0001_0000_0000_0000}, 9'd127,  '{32'h4000_0000, 1'b0, 1'b0, 1'b0}};
    vecs[2]  = '{{1'b1, 64'h0001_0000_0000_0000}, 9'd254,  '{32'hFF80_0000, 1'b1, 1'b0, 1'b0}};
    vecs[3]  = '{{1'b0, 64'h0000_8000_0000_0000}, 9'd0,    '{32'h0000_0000, 1'b0, 1'b1, 1'b0}};
    vecs[4]  = '{{1'b0, 64'h0000_8000_0000_0000}, 9'h1F0,  '{32'h0000_0000, 1'b0, 1'b1, 1'b0}};
    vecs[5]  = '{{1'b1, 64'h0000_0000_0000_0000}, 9'd130,  '{32'h8000_0000, 1'b0, 1'b0, 1'b1}};
    vecs[6]  = '{{1'b0, 64'h0000_FFFF_FF00_0000}, 9'd127,  '{32'h3FFF_FFFF, 1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{{1'b0, 64'h0001_0000_0000_0000}, 9'd0,    '{32'h0080_0000, 1'b0, 1'b0, 1'b0}};
    vecs[8]  = '{{1'b0, 64'h0000_8000_0000_0000}, 9'd1,    '{32'h0080_0000, 1'b0, 1'b0, 1'b0}};
    vecs[9]  = '{{1'b0, 64'h0000_8000_0000_0000}, 9'd254,  '{32'h7F00_0000, 1'b0, 1'b0, 1'b0}};
    vecs[10] = '{{1'b0, 64'h0000_8000_0000_0000}, 9'd255,  '{32'h7F80_0000, 1'b1, 1'b0, 1'b0}};
    vecs[11] = '{{1'b0, 64'hFFFE_C000_00FF_FFFF}, 9'd128,  '{32'h4040_0000, 1'b0, 1'b0, 1'b0}};
    vecs[12] = '{{1'b1, 64'h0001_0000_0000_0000}, 9'h100,  '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
    vecs[13] = '{{1'b0, 64'h0000_4000_0000_0000}, 9'd100,  '{32'h0000_0000, 1'b0, 1'b0, 1'b1}};
    vecs[14] = '{{1'b0, 64'h0001_FFFF_FE00_0000}, 9'd126,  '{32'h3FFF_FFFF, 1'b0, 1'b0, 1'b0}};

    ma_v = 1'b0; ma_out = '0; m_valid = 1'b0; m_out = '0; m_sovf = 1'b0; m_sunf = 1'b0;
    x2 = 65'h0; base_ei = 9'h0; enable = 1'b0; flag_clr = 1'b0; rst = 1'b1;

    // reset state
    step(65'h0, 9'h0, 1'b0, 1'b0, 1'b1);
    step(65'h0, 9'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {25'h0, valid, ovf, unf, zero, sticky_ovf, sticky_unf, 1'b0}, 32'h0);

    // directed table: op then one idle -> result visible two edges after enable
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].x2, vecs[i].base, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      chk($sformatf("vec%0d_valid", i), {31'h0, valid}, 32'h1);
      chk($sformatf("vec%0d_result", i), result, vecs[i].e.res);
      chk($sformatf("vec%0d_flags", i), {29'h0, ovf, unf, zero},
          {29'h0, vecs[i].e.ovf, vecs[i].e.unf, vecs[i].e.zero});
      idle(1'b1);
    end

    // enable 1,1,0,1: results in order, gap holds the previous one
    step(vecs[0].x2, vecs[0].base, 1'b1, 1'b0, 1'b0);
    step(vecs[1].x2, vecs[1].base, 1'b1, 1'b0, 1'b0);
    step(65'h0, 9'h0, 1'b0, 1'b0, 1'b0);
    chk("seq_op1", {valid, result[30:0]}, {1'b1, vecs[1].e.res[30:0]});
    step(vecs[9].x2, vecs[9].base, 1'b1, 1'b0, 1'b0);
    chk("seq_gap_hold", {valid, result[30:0]}, {1'b0, vecs[1].e.res[30:0]});
    idle(1'b0);
    chk("seq_op3", {valid, result[30:0]}, {1'b1, vecs[9].e.res[30:0]});
    idle(1'b0);

    // clear in the same cycle as a valid overflow: event wins
    idle(1'b1);
    step(vecs[2].x2, vecs[2].base, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    chk("sticky_set_vs_clr", {31'h0, sticky_ovf}, 32'h1);
    idle(1'b1);
    chk("sticky_cleared", {31'h0, sticky_ovf}, 32'h0);

    // reset with an op in stage A: nothing emitted afterwards
    step(vecs[0].x2, vecs[0].base, 1'b1, 1'b0, 1'b0);
    step(65'h0, 9'h0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("rst_flush_valid0", {31'h0, valid}, 32'h0);
    idle(1'b0);
    chk("rst_flush_valid1", {31'h0, valid}, 32'h0);
    chk("rst_flush_result", result, 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rx = {$urandom(), $urandom(), $urandom()};
      cat = $urandom_range(0, 3);
      case (cat)
        0: rx[48] = 1'b1;
        1: begin rx[48] = 1'b0; rx[47] = 1'b1; end
        2: rx[48:47] = 2'b00;
        default: rx = rx;
      endcase
      rb = 9'($urandom());
      if ($urandom_range(0, 3) == 0) rb = 9'($urandom_range(250, 260));
      if ($urandom_range(0, 5) == 0) rb = 9'($urandom_range(0, 2));
      step(rx, rb, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 99) == 0);
    end
    idle(1'b0);
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
